// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, diff = a - b.
// One full-subtractor cell with a registered borrow processes one bit per clock,
// LSB first. A run takes WIDTH cycles from the accepting edge to the done pulse.
// Optional feature: define SERIAL_SUB_OVF_EN to add the registered signed
// overflow output ovf.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  res_q;
    logic              br_q;
    logic              busy_q;
    logic              done_q;
    logic              bout_q;
`ifdef SERIAL_SUB_OVF_EN
    logic              ovf_q;
`endif

    logic              x;
    logic              y;
    logic              d_bit;
    logic              br_nxt;
    logic              last_bit;

    // Full-subtractor cell on the current LSBs plus the stored borrow.
    always_comb begin
        x        = a_q[0];
        y        = b_q[0];
        d_bit    = x ^ y ^ br_q;
        br_nxt   = (~x & y) | (~(x ^ y) & br_q);
        last_bit = (cnt_q == CntW'(WIDTH - 1));
    end

    // Sequencer and datapath; a run always passes back through idle after done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end
                end
                StShift: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= {d_bit, res_q[WIDTH-1:1]};
                    br_q  <= br_nxt;
                    cnt_q <= cnt_q + CntW'(1);
                    if (last_bit) begin
                        bout_q  <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        // Borrow into the MSB differs from borrow out: signed overflow.
                        ovf_q   <= br_q ^ br_nxt;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // All outputs come straight from registers.
    always_comb begin
        busy = busy_q;
        done = done_q;
        diff = res_q;
        bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf  = ovf_q;
`endif
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed bench for serial_subtractor at WIDTH = 8.
// Checks ovf as well when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction: accept, count latency and busy cycles, then check the result.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] exp_diff, input logic exp_bout,
                          input logic exp_ovf);
        int n;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~va;
        b     = ~vb;
        n        = 0;
        busy_cnt = 0;
        while (!done && n < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("latency", n, W);
        check_eq("busy_cycles", busy_cnt, W);
        check_eq("busy_at_done", busy, 1'b0);
        check_eq("diff", diff, exp_diff);
        check_eq("bout", bout, exp_bout);
`ifdef SERIAL_SUB_OVF_EN
        check_eq("ovf", ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("unexpected ovf expectation");
`endif
        @(posedge clk);
        #1;
        check_eq("done_pulse_end", done, 1'b0);
        check_eq("diff_hold", diff, exp_diff);
    endtask

    logic [8:0]   exp_q[$];
    logic [8:0]   exp_v;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic         prev_busy;
    int           last_acc;
    int           n_acc;
    int           n_overlap;
    int           n_done;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #2;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_diff", diff, 8'h00);
        check_eq("rst_bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check_eq("rst_ovf", ovf, 1'b0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h35, 8'h12, 8'h23, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        run_op(8'h12, 8'h35, 8'hDD, 1'b1, 1'b0);
        run_op(8'h01, 8'h80, 8'h81, 1'b1, 1'b1);
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

        // start held high with operands changing every cycle.
        // Accept -> 8 shift -> done -> idle -> accept gives a 10-cycle period.
        prev_busy = 1'b0;
        last_acc  = -1;
        n_acc     = 0;
        n_overlap = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            start = 1'b1;
            a     = 8'(c * 37 + 5);
            b     = 8'(c * 11 + 200);
            ea    = a;
            eb    = b;
            @(posedge clk);
            #1;
            if (busy && done) n_overlap++;
            if (busy && !prev_busy) begin
                exp_v = {(ea < eb), 8'(ea - eb)};
                exp_q.push_back(exp_v);
                if (last_acc >= 0) check_eq("accept_interval", c - last_acc, 10);
                last_acc = c;
                n_acc++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_done", 1'b1, 1'b0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check_eq("held_diff", diff, exp_v[7:0]);
                    check_eq("held_bout", bout, exp_v[8]);
                end
            end
            prev_busy = busy;
        end
        start = 1'b0;
        check_eq("held_accepts", (n_acc >= 3), 1'b1);
        check_eq("no_overlap", n_overlap, 0);
        repeat (12) @(negedge clk);

        // Reset during the 4th shift cycle.
        @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h0F;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("pre_rst_busy", busy, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_diff", diff, 8'h00);
        check_eq("abort_bout", bout, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        n_done = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done || busy) n_done++;
        end
        check_eq("no_done_after_abort", n_done, 0);

        run_op(8'h10, 8'h10, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
